// File: rtl/decoder_pkg.sv
// Shared definitions for the scanning one-hot decoder: mode encoding and FSM states.
package decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 while run is high and flags the terminal count.
// clear has priority over run and returns the count to zero.
module dwell_timer #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    // Terminal-count flag; only meaningful while the timer is running.
    always_comb begin
        tick = 1'b0;
        if (run && (cnt_r == TERM)) begin
            tick = 1'b1;
        end else begin
            tick = 1'b0;
        end
    end

    // Next count: clear wins, then count with roll-over on the terminal value, else hold.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clear) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (run) begin
            if (cnt_r == TERM) begin
                cnt_nxt_s = {CNT_W{1'b0}};
            end else begin
                cnt_nxt_s = cnt_r + CNT_W'(1'b1);
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

endmodule

// File: rtl/decoder_nx_scan.sv
// One-hot decoder with a direct (latched select) mode and an auto-rotating scan mode.
// outputs, index and wrap are all registered; outputs reflect the index that is
// valid after the same edge, so a load shows up one cycle later on both.
module decoder_nx_scan
    import decoder_pkg::*;
#(
    parameter  int IN_WIDTH  = 3,
    parameter  int DWELL     = 4,
    localparam int OUT_WIDTH = 1 << IN_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enabled,
    input  logic                 mode,
    input  logic [IN_WIDTH-1:0]  inputs,
    input  logic                 load,
    output logic [OUT_WIDTH-1:0] outputs,
    output logic [IN_WIDTH-1:0]  index,
    output logic                 wrap
);

    localparam logic [IN_WIDTH-1:0] LAST_IDX = {IN_WIDTH{1'b1}};

    state_t                state_r;
    state_t                next_state_s;
    logic                  run_s;
    logic                  clear_s;
    logic                  tick_s;
    logic [IN_WIDTH-1:0]   index_r;
    logic [IN_WIDTH-1:0]   index_nxt_s;
    logic                  wrap_r;
    logic                  wrap_nxt_s;
    logic [OUT_WIDTH-1:0]  outputs_r;
    logic [OUT_WIDTH-1:0]  outputs_nxt_s;

    // Next-state selection and dwell-timer control, re-evaluated every cycle.
    always_comb begin
        next_state_s = ST_IDLE;
        run_s        = 1'b0;
        clear_s      = 1'b0;
        if (!enabled) begin
            next_state_s = ST_IDLE;
        end else if (mode == MODE_SCAN) begin
            next_state_s = ST_SCAN;
        end else begin
            next_state_s = ST_DIRECT;
        end

        case (next_state_s)
            ST_SCAN: begin
                // The first SCAN cycle only clears, so the first dwell is full length.
                run_s   = (state_r == ST_SCAN);
                clear_s = load || (state_r != ST_SCAN);
            end
            ST_DIRECT: begin
                run_s   = 1'b0;
                clear_s = 1'b1;
            end
            ST_IDLE: begin
                run_s   = 1'b0;
                clear_s = load;
            end
            default: begin
                run_s   = 1'b0;
                clear_s = 1'b1;
            end
        endcase
    end

    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear_s),
        .run   (run_s),
        .tick  (tick_s)
    );

    // Index update: load beats an advance and suppresses wrap; one-hot follows the new index.
    always_comb begin
        index_nxt_s   = index_r;
        wrap_nxt_s    = 1'b0;
        outputs_nxt_s = {OUT_WIDTH{1'b0}};
        if (load) begin
            index_nxt_s = inputs;
            wrap_nxt_s  = 1'b0;
        end else if (tick_s) begin
            index_nxt_s = index_r + IN_WIDTH'(1'b1);
            wrap_nxt_s  = (index_r == LAST_IDX);
        end else begin
            index_nxt_s = index_r;
            wrap_nxt_s  = 1'b0;
        end

        if (next_state_s != ST_IDLE) begin
            outputs_nxt_s = OUT_WIDTH'(1'b1) << index_nxt_s;
        end else begin
            outputs_nxt_s = {OUT_WIDTH{1'b0}};
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            index_r   <= {IN_WIDTH{1'b0}};
            wrap_r    <= 1'b0;
            outputs_r <= {OUT_WIDTH{1'b0}};
        end else begin
            state_r   <= next_state_s;
            index_r   <= index_nxt_s;
            wrap_r    <= wrap_nxt_s;
            outputs_r <= outputs_nxt_s;
        end
    end

    assign outputs = outputs_r;
    assign index   = index_r;
    assign wrap    = wrap_r;

endmodule

// File: tb/tb_decoder_nx_scan.sv
// Directed bench for decoder_nx_scan (IN_WIDTH=3): main instance with DWELL=4,
// second instance with DWELL=1 sharing the same stimulus.
module tb_decoder_nx_scan;

    logic       clk;
    logic       rst_n;
    logic       enabled;
    logic       mode;
    logic [2:0] inputs;
    logic       load;
    logic [7:0] outputs0;
    logic [2:0] index0;
    logic       wrap0;
    logic [7:0] outputs1;
    logic [2:0] index1;
    logic       wrap1;

    int checks;
    int failures;

    decoder_nx_scan #(.IN_WIDTH(3), .DWELL(4)) dut (
        .clk(clk), .rst_n(rst_n), .enabled(enabled), .mode(mode),
        .inputs(inputs), .load(load),
        .outputs(outputs0), .index(index0), .wrap(wrap0)
    );

    decoder_nx_scan #(.IN_WIDTH(3), .DWELL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .enabled(enabled), .mode(mode),
        .inputs(inputs), .load(load),
        .outputs(outputs1), .index(index1), .wrap(wrap1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (outputs0 !== 8'h00) begin failures++; $display("FAIL reset_outputs got=%h exp=%h", outputs0, 8'h00); end
        checks++; if (index0 !== 3'd0) begin failures++; $display("FAIL reset_index got=%0d exp=0", index0); end
        checks++; if (wrap0 !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", wrap0); end
        checks++; if (outputs1 !== 8'h00) begin failures++; $display("FAIL reset_outputs1 got=%h exp=00", outputs1); end
        step();
        step();
    endtask

    task automatic test_direct_load();
        rst_n   = 1'b1;
        enabled = 1'b1;
        mode    = 1'b0;
        inputs  = 3'd5;
        load    = 1'b1;
        step();
        load    = 1'b0;
        inputs  = 3'd1;
        checks++; if (outputs0 !== 8'b0010_0000) begin failures++; $display("FAIL direct_outputs got=%b exp=00100000", outputs0); end
        checks++; if (index0 !== 3'd5) begin failures++; $display("FAIL direct_index got=%0d exp=5", index0); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (outputs0 !== 8'b0010_0000 || index0 !== 3'd5) begin failures++; $display("FAIL direct_hold cyc=%0d got=%b/%0d exp=00100000/5", i, outputs0, index0); end
        end
    endtask

    task automatic test_scan_wrap();
        logic [2:0] exp_idx;
        logic [7:0] exp_out;
        logic       exp_wrap;
        inputs = 3'd6;
        load   = 1'b1;
        step();
        load   = 1'b0;
        mode   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            exp_idx  = (i < 4) ? 3'd6 : ((i < 8) ? 3'd7 : 3'd0);
            exp_out  = (i < 4) ? 8'b0100_0000 : ((i < 8) ? 8'b1000_0000 : 8'b0000_0001);
            exp_wrap = (i == 8);
            checks++; if (index0 !== exp_idx) begin failures++; $display("FAIL scan_index cyc=%0d got=%0d exp=%0d", i, index0, exp_idx); end
            checks++; if (outputs0 !== exp_out) begin failures++; $display("FAIL scan_outputs cyc=%0d got=%b exp=%b", i, outputs0, exp_out); end
            checks++; if (wrap0 !== exp_wrap) begin failures++; $display("FAIL scan_wrap cyc=%0d got=%b exp=%b", i, wrap0, exp_wrap); end
        end
    endtask

    task automatic test_load_on_advance();
        logic [2:0] exp_idx;
        // Load 7 in SCAN: counter restarts, the wrapping advance is due 4 edges later.
        inputs = 3'd7;
        load   = 1'b1;
        step();
        load   = 1'b0;
        checks++; if (index0 !== 3'd7) begin failures++; $display("FAIL load_scan_index got=%0d exp=7", index0); end
        step();
        step();
        step();
        inputs = 3'd2;
        load   = 1'b1;
        step();
        load   = 1'b0;
        checks++; if (index0 !== 3'd2) begin failures++; $display("FAIL load_adv_index got=%0d exp=2", index0); end
        checks++; if (outputs0 !== 8'b0000_0100) begin failures++; $display("FAIL load_adv_outputs got=%b exp=00000100", outputs0); end
        checks++; if (wrap0 !== 1'b0) begin failures++; $display("FAIL load_adv_wrap got=%b exp=0", wrap0); end
        for (int i = 1; i <= 4; i++) begin
            step();
            exp_idx = (i < 4) ? 3'd2 : 3'd3;
            checks++; if (index0 !== exp_idx || wrap0 !== 1'b0) begin failures++; $display("FAIL load_adv_dwell cyc=%0d got=%0d/%b exp=%0d/0", i, index0, wrap0, exp_idx); end
        end
    endtask

    task automatic test_disable();
        logic [2:0] exp_idx;
        enabled = 1'b0;
        step();
        checks++; if (outputs0 !== 8'h00) begin failures++; $display("FAIL disable_outputs got=%b exp=00000000", outputs0); end
        checks++; if (index0 !== 3'd3) begin failures++; $display("FAIL disable_index got=%0d exp=3", index0); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (outputs0 !== 8'h00 || index0 !== 3'd3 || wrap0 !== 1'b0) begin failures++; $display("FAIL disable_hold cyc=%0d got=%b/%0d/%b exp=00000000/3/0", i, outputs0, index0, wrap0); end
        end
        enabled = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            exp_idx = (i < 4) ? 3'd3 : 3'd4;
            checks++; if (index0 !== exp_idx) begin failures++; $display("FAIL reenable_index cyc=%0d got=%0d exp=%0d", i, index0, exp_idx); end
            checks++; if (outputs0 !== ((i < 4) ? 8'b0000_1000 : 8'b0001_0000)) begin failures++; $display("FAIL reenable_outputs cyc=%0d got=%b", i, outputs0); end
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [2:0] exp_idx;
        step();
        checks++; if (index0 !== 3'd4) begin failures++; $display("FAIL premid_index got=%0d exp=4", index0); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (outputs0 !== 8'h00) begin failures++; $display("FAIL async_rst_outputs got=%b exp=00000000", outputs0); end
        checks++; if (index0 !== 3'd0) begin failures++; $display("FAIL async_rst_index got=%0d exp=0", index0); end
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            exp_idx = (i < 4) ? 3'd0 : 3'd1;
            checks++; if (index0 !== exp_idx) begin failures++; $display("FAIL post_rst_index cyc=%0d got=%0d exp=%0d", i, index0, exp_idx); end
            checks++; if (outputs0 !== ((i < 4) ? 8'b0000_0001 : 8'b0000_0010)) begin failures++; $display("FAIL post_rst_outputs cyc=%0d got=%b", i, outputs0); end
            checks++; if (wrap0 !== 1'b0) begin failures++; $display("FAIL post_rst_wrap cyc=%0d got=%b exp=0", i, wrap0); end
        end
    endtask

    task automatic test_dwell1();
        logic [2:0] exp_idx;
        logic [7:0] one;
        logic [7:0] exp_out;
        one   = 8'd1;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 18; i++) begin
            step();
            exp_idx = 3'(i % 8);
            exp_out = one << exp_idx;
            checks++; if (index1 !== exp_idx) begin failures++; $display("FAIL dwell1_index cyc=%0d got=%0d exp=%0d", i, index1, exp_idx); end
            checks++; if (outputs1 !== exp_out) begin failures++; $display("FAIL dwell1_outputs cyc=%0d got=%b exp=%b", i, outputs1, exp_out); end
            checks++; if (wrap1 !== ((i > 0) && (i % 8 == 0))) begin failures++; $display("FAIL dwell1_wrap cyc=%0d got=%b", i, wrap1); end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        enabled  = 1'b0;
        mode     = 1'b0;
        inputs   = 3'd0;
        load     = 1'b0;
        test_reset();
        test_direct_load();
        test_scan_wrap();
        test_load_on_advance();
        test_disable();
        test_reset_mid_scan();
        test_dwell1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
